// File: rtl/cart_loader.sv
// cart_loader: converts the host 16-bit ROM download stream into the byte-wide
// cartridge ROM init stream, pads the image with a fill byte up to the next
// size class (8K/16K/32K/64K/128K), and reports size class and completion.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_ioctl_download/index  host download window and download index
//   i_ioctl_wr/addr/dout    one-cycle word strobe, byte address, word data
//   o_ioctl_wait            host must not strobe while high
//   o_init_addr/data/valid  one cartridge ROM byte write per valid cycle
//   o_byte_count            highest written byte address + 1
//   o_size_class            0=8K .. 4=128K, latched when the image closes
//   o_loaded                image complete and padded
//   o_trunc, o_overrun      sticky: out-of-range data, strobe while busy
module cart_loader #(
  parameter logic [7:0] ROM_INDEX = 8'd1,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ioctl_download,
  input  logic [7:0]  i_ioctl_index,
  input  logic        i_ioctl_wr,
  input  logic [24:0] i_ioctl_addr,
  input  logic [15:0] i_ioctl_dout,
  output logic        o_ioctl_wait,
  output logic [16:0] o_init_addr,
  output logic [7:0]  o_init_data,
  output logic        o_init_valid,
  output logic [17:0] o_byte_count,
  output logic [2:0]  o_size_class,
  output logic        o_loaded,
  output logic        o_trunc,
  output logic        o_overrun
);

  typedef enum logic [1:0] {StIdle, StLoad, StHi, StFill} state_e;

  state_e      r_state;
  logic        r_active;
  logic        r_wait;
  logic [16:0] r_init_addr;
  logic [7:0]  r_init_data;
  logic        r_init_valid;
  logic [7:0]  r_hi_data;
  logic [17:0] r_byte_count;
  logic [2:0]  r_size_class;
  logic        r_loaded;
  logic        r_trunc;
  logic        r_overrun;

  logic        w_active;
  logic        w_rise;
  logic        w_strobe;
  logic        w_in_range;
  logic [17:0] w_word_end;
  logic [2:0]  w_class;
  logic [17:0] w_cap;
  logic        w_exact;
  logic [16:0] w_fill_last;

  assign w_active    = i_ioctl_download && (i_ioctl_index == ROM_INDEX);
  assign w_rise      = w_active && !r_active;
  assign w_strobe    = w_active && i_ioctl_wr;
  assign w_in_range  = (i_ioctl_addr[24:17] == 8'd0);
  assign w_word_end  = {1'b0, i_ioctl_addr[16:0]} + 18'd2;

  // Smallest class whose capacity covers the current image.
  always_comb begin
    w_class = 3'd4;
    if (r_byte_count <= 18'd8192) begin
      w_class = 3'd0;
    end else if (r_byte_count <= 18'd16384) begin
      w_class = 3'd1;
    end else if (r_byte_count <= 18'd32768) begin
      w_class = 3'd2;
    end else if (r_byte_count <= 18'd65536) begin
      w_class = 3'd3;
    end
  end

  assign w_cap       = 18'd8192 << w_class;
  assign w_exact     = (r_byte_count == 18'd0) || (r_byte_count == w_cap);
  assign w_fill_last = 17'((18'd8192 << r_size_class) - 18'd1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_active     <= 1'b0;
      r_wait       <= 1'b0;
      r_init_addr  <= 17'd0;
      r_init_data  <= 8'd0;
      r_init_valid <= 1'b0;
      r_hi_data    <= 8'd0;
      r_byte_count <= 18'd0;
      r_size_class <= 3'd0;
      r_loaded     <= 1'b0;
      r_trunc      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_active     <= w_active;
      r_init_valid <= 1'b0;
      // A download start in the same cycle clears this again below.
      if (w_strobe && r_wait) begin
        r_overrun <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (w_rise) begin
            r_state      <= StLoad;
            r_byte_count <= 18'd0;
            r_loaded     <= 1'b0;
            r_trunc      <= 1'b0;
            r_overrun    <= 1'b0;
          end
        end
        StLoad: begin
          if (!w_active) begin
            r_size_class <= w_class;
            if (w_exact) begin
              r_state  <= StIdle;
              r_wait   <= 1'b0;
              r_loaded <= 1'b1;
            end else begin
              r_state      <= StFill;
              r_wait       <= 1'b1;
              r_init_valid <= 1'b1;
              r_init_addr  <= r_byte_count[16:0];
              r_init_data  <= FILL_BYTE;
            end
          end else begin
            // Wait covers the low- and high-byte output cycles.
            r_wait <= 1'b0;
            if (i_ioctl_wr && !r_wait) begin
              if (w_in_range) begin
                r_state      <= StHi;
                r_wait       <= 1'b1;
                r_init_valid <= 1'b1;
                r_init_addr  <= i_ioctl_addr[16:0];
                r_init_data  <= i_ioctl_dout[7:0];
                r_hi_data    <= i_ioctl_dout[15:8];
                if (w_word_end > r_byte_count) begin
                  r_byte_count <= w_word_end;
                end
              end else begin
                r_trunc <= 1'b1;
              end
            end
          end
        end
        StHi: begin
          // Completes even if the download has just dropped.
          r_state      <= StLoad;
          r_init_valid <= 1'b1;
          r_init_addr  <= r_init_addr + 17'd1;
          r_init_data  <= r_hi_data;
        end
        StFill: begin
          if (w_rise) begin
            r_state      <= StLoad;
            r_wait       <= 1'b0;
            r_byte_count <= 18'd0;
            r_loaded     <= 1'b0;
            r_trunc      <= 1'b0;
            r_overrun    <= 1'b0;
          end else if (r_init_addr == w_fill_last) begin
            r_state  <= StIdle;
            r_wait   <= 1'b0;
            r_loaded <= 1'b1;
          end else begin
            r_init_valid <= 1'b1;
            r_init_addr  <= r_init_addr + 17'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_ioctl_wait = r_wait;
  assign o_init_addr  = r_init_addr;
  assign o_init_data  = r_init_data;
  assign o_init_valid = r_init_valid;
  assign o_byte_count = r_byte_count;
  assign o_size_class = r_size_class;
  assign o_loaded     = r_loaded;
  assign o_trunc      = r_trunc;
  assign o_overrun    = r_overrun;

endmodule
